// File: rtl/bus_addr_arb_if.sv
// Bus bundle between the requesting master, the address arbiter and its slaves.
// The "slave" modport is the arbiter side; the "master" modport is the environment side.
interface bus_addr_arb_if #(
   parameter int ADDR_W = 16,
   parameter int NSLV   = 2
);
   logic              m_req;
   logic [ADDR_W-1:0] m_addr;
   logic [NSLV-1:0]   s_ack;
   logic [NSLV-1:0]   s_sel;
   logic              m_busy;
   logic              m_done;
   logic              m_err;
   logic              m_to;

   modport master (
      output m_req, m_addr, s_ack,
      input  s_sel, m_busy, m_done, m_err, m_to
   );

   modport slave (
      input  m_req, m_addr, s_ack,
      output s_sel, m_busy, m_done, m_err, m_to
   );
endinterface

// File: rtl/bus_addr_arb.sv
// Address-decoding arbiter: maps a master request onto one slave region, waits
// for that slave's ack or a timeout, and reports done/error as one-cycle pulses.
module bus_addr_arb #(
   parameter int                     ADDR_W  = 16,
   parameter int                     NSLV    = 2,
   parameter logic [NSLV*ADDR_W-1:0] S_BASE  = {16'h7000, 16'h0000},
   parameter logic [NSLV*ADDR_W-1:0] S_LAST  = {16'h71FF, 16'h07FF},
   parameter int                     TIMEOUT = 16
) (
   input  logic           clk,
   input  logic           reset_n,
   bus_addr_arb_if.slave  bus
);
   localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

   typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_t;

   state_t           r_state, w_state_next;
   logic [NSLV-1:0]  r_sel, w_sel_next;
   logic [CNT_W-1:0] r_cnt, w_cnt_next;
   logic             r_done, w_done_next;
   logic             r_to, w_to_next;
   logic [NSLV-1:0]  w_hit, w_hit_oh;
   logic             w_ack_ok, w_expire;

   genvar gi;
   generate
      for (gi = 0; gi < NSLV; gi++) begin : g_hit
         assign w_hit[gi] = (bus.m_addr >= S_BASE[gi*ADDR_W +: ADDR_W]) &&
                            (bus.m_addr <= S_LAST[gi*ADDR_W +: ADDR_W]);
      end
   endgenerate

   // Isolating the lowest set bit gives lowest-index priority on overlaps.
   assign w_hit_oh = w_hit & (~w_hit + NSLV'(1));
   assign w_ack_ok = |(bus.s_ack & r_sel);
   assign w_expire = (TIMEOUT > 0) && (r_cnt == CNT_LAST);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= IDLE;
         r_sel   <= '0;
         r_cnt   <= '0;
         r_done  <= 1'b0;
         r_to    <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_sel   <= w_sel_next;
         r_cnt   <= w_cnt_next;
         r_done  <= w_done_next;
         r_to    <= w_to_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      w_sel_next   = r_sel;
      w_cnt_next   = r_cnt;
      w_done_next  = 1'b0;
      w_to_next    = 1'b0;
      case (r_state)
         IDLE: begin
            if (bus.m_req) begin
               if (|w_hit) begin
                  w_state_next = ACTIVE;
                  w_sel_next   = w_hit_oh;
                  w_cnt_next   = '0;
               end else begin
                  w_state_next = ERR;
                  w_sel_next   = '0;
               end
            end
         end
         ACTIVE: begin
            // A valid ack wins over a simultaneous timeout expiry.
            if (w_ack_ok) begin
               w_state_next = IDLE;
               w_sel_next   = '0;
               w_done_next  = 1'b1;
            end else if (w_expire) begin
               w_state_next = IDLE;
               w_sel_next   = '0;
               w_to_next    = 1'b1;
            end else begin
               w_cnt_next = r_cnt + CNT_W'(1);
            end
         end
         ERR: begin
            w_state_next = IDLE;
            w_sel_next   = '0;
         end
         default: begin
            w_state_next = IDLE;
            w_sel_next   = '0;
         end
      endcase
   end

   always_comb begin
      bus.s_sel  = r_sel;
      bus.m_busy = (r_state != IDLE);
      bus.m_done = r_done;
      bus.m_err  = (r_state == ERR) | r_to;
      bus.m_to   = r_to;
   end
endmodule
